// File: rtl/alu_req_initiator_pkg.sv
// Shared types for the ALU request initiator and the asynchronous ALU.
package alu_req_initiator_pkg;

   localparam int unsigned ALU_XLEN = 32;

   // ALU operator encoding, shared with the ALU itself
   typedef enum logic [3:0] {
      ADD = 4'd0,
      SUB = 4'd1,
      SRA = 4'd2,
      SRL = 4'd3,
      SLL = 4'd4,
      XOR = 4'd5,
      OR  = 4'd6,
      AND = 4'd7,
      LT  = 4'd8,
      LTU = 4'd9,
      GE  = 4'd10,
      GEU = 4'd11,
      EQ  = 4'd12,
      NE  = 4'd13
   } alu_op;

   // Initiator handshake states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      REQ_HI = 3'd2,
      REQ_LO = 3'd3,
      RESP   = 3'd4
   } init_state_e;

   // Bundled-data payload presented to the ALU
   typedef struct packed {
      alu_op               op;
      logic [ALU_XLEN-1:0] a;
      logic [ALU_XLEN-1:0] b;
   } alu_cmd_t;

endpackage

// File: rtl/alu_req_initiator_sync_ff.sv
// N-stage single-bit synchroniser with synchronous active-high reset.
module alu_req_initiator_sync_ff #(
   parameter int unsigned N = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [N-1:0] r_sync;

   // Shift the asynchronous input through N flops
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[N-2:0], d_i};
      end
   end

   assign q_o = r_sync[N-1];

endmodule

// File: rtl/alu_req_initiator.sv
// Synchronous initiator for the asynchronous ALU's four-phase req/ack port.
module alu_req_initiator
   import alu_req_initiator_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  alu_op               cmd_op_i,
   input  logic [ALU_XLEN-1:0] cmd_a_i,
   input  logic [ALU_XLEN-1:0] cmd_b_i,
   output logic                alu_req_o,
   input  logic                alu_ack_i,
   output logic                alu_rst_no,
   output alu_op               alu_op_o,
   output logic [ALU_XLEN-1:0] alu_a_o,
   output logic [ALU_XLEN-1:0] alu_b_o,
   input  logic [ALU_XLEN-1:0] alu_result_i,
   output logic                res_valid_o,
   input  logic                res_ready_i,
   output logic [ALU_XLEN-1:0] res_data_o,
   output logic                res_err_o,
   output logic                busy_o
);

   localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(TIMEOUT_CYCLES);
   localparam bit                WDOG_EN   = (TIMEOUT_CYCLES > 0);

   init_state_e         r_state;
   init_state_e         w_next_state;
   alu_cmd_t            r_cmd;
   logic                r_req;
   logic                r_res_valid;
   logic [ALU_XLEN-1:0] r_res_data;
   logic                r_res_err;
   logic [WDOG_W-1:0]   r_wdog;
   logic                r_cmd_ready;
   logic                r_busy;

   logic                w_ack_s;
   logic                w_cmd_hs;
   logic                w_req_rise;
   logic                w_capture;
   logic                w_timeout;
   logic                w_valid_rise;
   logic                w_res_hs;

   // Only the synchronised ack is ever looked at
   alu_req_initiator_sync_ff #(
      .N (SYNC_STAGES)
   ) u_ack_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (alu_ack_i),
      .q_o   (w_ack_s)
   );

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and per-transition strobes
   always_comb begin
      w_next_state = r_state;
      w_cmd_hs     = 1'b0;
      w_req_rise   = 1'b0;
      w_capture    = 1'b0;
      w_timeout    = 1'b0;
      w_valid_rise = 1'b0;
      w_res_hs     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (cmd_valid_i) begin
               w_cmd_hs     = 1'b1;
               w_next_state = SETUP;
            end
         end
         SETUP: begin
            // A late ack from an abandoned operation must drain before req rises
            if (!w_ack_s) begin
               w_req_rise   = 1'b1;
               w_next_state = REQ_HI;
            end
         end
         REQ_HI: begin
            if (w_ack_s) begin
               w_capture    = 1'b1;
               w_next_state = REQ_LO;
            end else if (WDOG_EN && (r_wdog == WDOG_LAST)) begin
               w_timeout    = 1'b1;
               w_next_state = REQ_LO;
            end
         end
         REQ_LO: begin
            if (!w_ack_s) begin
               w_valid_rise = 1'b1;
               w_next_state = RESP;
            end
         end
         RESP: begin
            if (res_ready_i) begin
               w_res_hs     = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Datapath, handshake and watchdog registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cmd       <= '{op: ADD, a: '0, b: '0};
         r_req       <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_err   <= 1'b0;
         r_wdog      <= '0;
         r_cmd_ready <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         r_cmd_ready <= (w_next_state == IDLE);
         r_busy      <= (w_next_state != IDLE);
         if (w_cmd_hs) begin
            r_cmd <= '{op: cmd_op_i, a: cmd_a_i, b: cmd_b_i};
         end
         if (w_req_rise) begin
            r_req <= 1'b1;
         end else if (w_capture || w_timeout) begin
            r_req <= 1'b0;
         end
         if (w_capture) begin
            r_res_data <= alu_result_i;
            r_res_err  <= 1'b0;
         end else if (w_timeout) begin
            r_res_data <= '0;
            r_res_err  <= 1'b1;
         end
         if (w_valid_rise) begin
            r_res_valid <= 1'b1;
         end else if (w_res_hs) begin
            r_res_valid <= 1'b0;
         end
         if (r_state == SETUP) begin
            r_wdog <= '0;
         end else if ((r_state == REQ_HI) && (r_wdog != WDOG_MAX)) begin
            r_wdog <= r_wdog + WDOG_W'(1);
         end
      end
   end

   assign cmd_ready_o = r_cmd_ready & ~rst_i;
   assign alu_rst_no  = ~rst_i;
   assign alu_req_o   = r_req;
   assign alu_op_o    = r_cmd.op;
   assign alu_a_o     = r_cmd.a;
   assign alu_b_o     = r_cmd.b;
   assign res_valid_o = r_res_valid;
   assign res_data_o  = r_res_data;
   assign res_err_o   = r_res_err;
   assign busy_o      = r_busy;

endmodule

// File: tb/tb_alu_req_initiator.sv
// Self-checking bench for alu_req_initiator with a behavioural ALU responder.
module tb_alu_req_initiator;
   import alu_req_initiator_pkg::*;

   localparam int SYNC = 2;
   localparam int TMO  = 8;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   alu_op       cmd_op_i = ADD;
   logic [31:0] cmd_a_i = '0;
   logic [31:0] cmd_b_i = '0;
   logic        alu_req_o;
   logic        alu_ack_i = 1'b0;
   logic        alu_rst_no;
   alu_op       alu_op_o;
   logic [31:0] alu_a_o;
   logic [31:0] alu_b_o;
   logic [31:0] alu_result_i = '0;
   logic        res_valid_o;
   logic        res_ready_i = 1'b0;
   logic [31:0] res_data_o;
   logic        res_err_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int accept_cyc = 0;
   int ack_dly = 3;
   bit never_ack = 1'b0;

   alu_req_initiator #(
      .SYNC_STAGES    (SYNC),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_op_i     (cmd_op_i),
      .cmd_a_i      (cmd_a_i),
      .cmd_b_i      (cmd_b_i),
      .alu_req_o    (alu_req_o),
      .alu_ack_i    (alu_ack_i),
      .alu_rst_no   (alu_rst_no),
      .alu_op_o     (alu_op_o),
      .alu_a_o      (alu_a_o),
      .alu_b_o      (alu_b_o),
      .alu_result_i (alu_result_i),
      .res_valid_o  (res_valid_o),
      .res_ready_i  (res_ready_i),
      .res_data_o   (res_data_o),
      .res_err_o    (res_err_o),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Reference ALU semantics
   function automatic logic [31:0] ref_alu(alu_op op, logic [31:0] a, logic [31:0] b);
      case (op)
         ADD:     return a + b;
         SUB:     return a - b;
         SRA:     return 32'($signed(a) >>> b[4:0]);
         SRL:     return a >> b[4:0];
         SLL:     return a << b[4:0];
         XOR:     return a ^ b;
         OR:      return a | b;
         AND:     return a & b;
         LT:      return {31'b0, $signed(a) < $signed(b)};
         LTU:     return {31'b0, a < b};
         GE:      return {31'b0, $signed(a) >= $signed(b)};
         GEU:     return {31'b0, a >= b};
         EQ:      return {31'b0, a == b};
         NE:      return {31'b0, a != b};
         default: return 32'h0;
      endcase
   endfunction

   // Four-phase ALU responder: ack after ack_dly, drop 3 units after req falls
   always begin
      @(posedge alu_req_o);
      if (!never_ack) begin
         #(ack_dly);
         if (alu_req_o) begin
            alu_result_i = ref_alu(alu_op_o, alu_a_o, alu_b_o);
            alu_ack_i    = 1'b1;
         end
      end
      if (alu_req_o) @(negedge alu_req_o);
      #3 alu_ack_i = 1'b0;
   end

   // Present a command and hold it until accepted (bounded)
   task automatic issue(input alu_op op, input logic [31:0] a, input logic [31:0] b);
      bit done = 1'b0;
      cmd_valid_i = 1'b1;
      cmd_op_i    = op;
      cmd_a_i     = a;
      cmd_b_i     = b;
      for (int i = 0; i < 60 && !done; i++) begin
         done = cmd_ready_o;
         @(posedge clk_i);
         @(negedge clk_i);
      end
      cmd_valid_i = 1'b0;
      accept_cyc  = cyc;
      if (!done) begin
         checks++; errors++;
         $display("FAIL issue_accept: cmd_ready_o never high for op %0d", op);
      end
   endtask

   // Wait for res_valid_o (bounded); counts req-high and cmd-ready cycles on the way
   task automatic wait_result(output logic [31:0] data, output logic err, output int lat,
                              output int req_cyc, output int rdy_cyc);
      bit got = 1'b0;
      data = '0; err = 1'b0; req_cyc = 0; rdy_cyc = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         if (res_valid_o) begin
            got  = 1'b1;
            data = res_data_o;
            err  = res_err_o;
         end else begin
            req_cyc += int'(alu_req_o);
            rdy_cyc += int'(cmd_ready_o);
            @(negedge clk_i);
         end
      end
      lat = cyc - accept_cyc;
      if (!got) begin
         checks++; errors++;
         $display("FAIL result_wait: res_valid_o never rose");
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_i);
      checks++;
      if ({cmd_ready_o, alu_rst_no, alu_req_o, res_valid_o, busy_o, res_err_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got rdy/rstn/req/vld/busy/err=%b want 000000",
                  {cmd_ready_o, alu_rst_no, alu_req_o, res_valid_o, busy_o, res_err_o});
      end
      checks++;
      if (alu_op_o !== ADD || alu_a_o !== 32'h0 || alu_b_o !== 32'h0 || res_data_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got op=%0d a=%h b=%h d=%h want 0 0 0 0",
                  alu_op_o, alu_a_o, alu_b_o, res_data_o);
      end
      rst_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (cmd_ready_o !== 1'b1 || alu_rst_no !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: got rdy=%b rstn=%b want 1 1", cmd_ready_o, alu_rst_no);
      end
   endtask

   task automatic test_add();
      logic [31:0] d; logic e; int lat, rq, rd;
      res_ready_i = 1'b1;
      ack_dly     = 3;
      issue(ADD, 32'h0, 32'h1);
      checks++;
      if (alu_op_o !== ADD || alu_a_o !== 32'h0 || alu_b_o !== 32'h1) begin
         errors++;
         $display("FAIL add_operands: got op=%0d a=%h b=%h want 0 0 1", alu_op_o, alu_a_o, alu_b_o);
      end
      wait_result(d, e, lat, rq, rd);
      checks++;
      if (d !== 32'h1 || e !== 1'b0) begin
         errors++;
         $display("FAIL add_result: got %h err=%b want 00000001 err=0", d, e);
      end
      checks++;
      if (rq !== SYNC + 1) begin
         errors++;
         $display("FAIL add_req_width: got %0d cycles want %0d", rq, SYNC + 1);
      end
      checks++;
      if (lat !== 3 + 2 * SYNC) begin
         errors++;
         $display("FAIL add_latency: got %0d want %0d", lat, 3 + 2 * SYNC);
      end
      @(negedge clk_i);
      checks++;
      if (res_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL add_consume: res_valid_o got %b want 0", res_valid_o);
      end
   endtask

   task automatic test_back_to_back();
      alu_op       ops[3] = '{SUB, SRA, LTU};
      logic [31:0] as[3]  = '{32'h40, 32'h80000000, 32'h4000};
      logic [31:0] bs[3]  = '{32'h1, 32'h1, 32'h80000001};
      logic [31:0] exp[3] = '{32'h3F, 32'hC0000000, 32'h1};
      logic [31:0] d; logic e; int lat, rq, rd;
      res_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], as[i], bs[i]);
         wait_result(d, e, lat, rq, rd);
         checks++;
         if (d !== exp[i] || e !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result[%0d]: got %h err=%b want %h err=0", i, d, e, exp[i]);
         end
         checks++;
         if (rd !== 0) begin
            errors++;
            $display("FAIL b2b_ready_low[%0d]: cmd_ready_o high %0d cycles want 0", i, rd);
         end
         @(negedge clk_i);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d; logic e; int lat, rq, rd;
      res_ready_i = 1'b0;
      issue(XOR, 32'h00080001, 32'h00010001);
      wait_result(d, e, lat, rq, rd);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         checks++;
         if ({res_valid_o, res_data_o, res_err_o, cmd_ready_o} !== {1'b1, 32'h00090000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got vld=%b d=%h err=%b rdy=%b want 1 00090000 0 0",
                     i, res_valid_o, res_data_o, res_err_o, cmd_ready_o);
         end
      end
      res_ready_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (res_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", res_valid_o, cmd_ready_o);
      end
   endtask

   task automatic test_timeout();
      logic [31:0] d; logic e; int lat, rq, rd;
      res_ready_i = 1'b1;
      never_ack   = 1'b1;
      issue(ADD, 32'h5, 32'h6);
      wait_result(d, e, lat, rq, rd);
      checks++;
      if (d !== 32'h0 || e !== 1'b1) begin
         errors++;
         $display("FAIL timeout_result: got %h err=%b want 00000000 err=1", d, e);
      end
      checks++;
      if (rq !== TMO) begin
         errors++;
         $display("FAIL timeout_req_width: got %0d cycles want %0d", rq, TMO);
      end
      @(negedge clk_i);
      never_ack = 1'b0;
      issue(EQ, 32'h1, 32'h1);
      wait_result(d, e, lat, rq, rd);
      checks++;
      if (d !== 32'h1 || e !== 1'b0) begin
         errors++;
         $display("FAIL timeout_recover: got %h err=%b want 00000001 err=0", d, e);
      end
      @(negedge clk_i);
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic e; int lat, rq, rd;
      res_ready_i = 1'b1;
      never_ack   = 1'b1;
      issue(GE, 32'h3, 32'h2);
      repeat (2) @(negedge clk_i);
      checks++;
      if (alu_req_o !== 1'b1 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre: got req=%b busy=%b want 1 1", alu_req_o, busy_o);
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if ({alu_req_o, busy_o, res_valid_o, alu_rst_no, cmd_ready_o} !== 5'b0) begin
         errors++;
         $display("FAIL midrst_state: got req/busy/vld/rstn/rdy=%b want 00000",
                  {alu_req_o, busy_o, res_valid_o, alu_rst_no, cmd_ready_o});
      end
      rst_i     = 1'b0;
      never_ack = 1'b0;
      @(negedge clk_i);
      issue(GEU, 32'h0, 32'h1);
      wait_result(d, e, lat, rq, rd);
      checks++;
      if (d !== 32'h0 || e !== 1'b0) begin
         errors++;
         $display("FAIL midrst_recover: got %h err=%b want 00000000 err=0", d, e);
      end
      @(negedge clk_i);
   endtask

   task automatic test_coincident();
      logic [31:0] d; logic e; int lat, rq, rd;
      res_ready_i = 1'b1;
      // ack_s first seen on exactly the last watchdog cycle
      ack_dly = 10 * (TMO - SYNC - 1) + 3;
      issue(SUB, 32'hA, 32'h3);
      wait_result(d, e, lat, rq, rd);
      checks++;
      if (d !== 32'h7 || e !== 1'b0) begin
         errors++;
         $display("FAIL coincide_result: got %h err=%b want 00000007 err=0", d, e);
      end
      checks++;
      if (rq !== TMO) begin
         errors++;
         $display("FAIL coincide_req_width: got %0d cycles want %0d", rq, TMO);
      end
      ack_dly = 3;
      @(negedge clk_i);
   endtask

   task automatic test_random();
      logic [31:0] d; logic e; int lat, rq, rd;
      alu_op op; logic [31:0] a, b;
      res_ready_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         op      = alu_op'(4'($urandom_range(13)));
         a       = $urandom;
         b       = ($urandom_range(1) == 0) ? 32'($urandom_range(40)) : $urandom;
         ack_dly = 3 + 10 * $urandom_range(2);
         issue(op, a, b);
         wait_result(d, e, lat, rq, rd);
         checks++;
         if (d !== ref_alu(op, a, b) || e !== 1'b0) begin
            errors++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h err=%b want %h err=0",
                     i, op, a, b, d, e, ref_alu(op, a, b));
         end
         @(negedge clk_i);
      end
      ack_dly = 3;
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      test_coincident();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "simulation time limit reached");
   end

endmodule
